// File: rtl/const_detect_pkg.sv
// -----------------------------------------------------------------------------
// const_detect_pkg
//
// Shared definitions for the constant-stream detector:
//   ST_SEARCH / ST_LOCKED : state encodings of the lock FSM
//   RUN_W                 : width of the consecutive-run counter
//   state_t               : typed FSM state built on those encodings
// -----------------------------------------------------------------------------
package const_detect_pkg;

    localparam logic ST_SEARCH = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    // Run counter width; LOCK_COUNT and MISS_LIMIT must fit (1..255).
    localparam int unsigned RUN_W = 8;

    typedef enum logic {
        StSearch = ST_SEARCH,
        StLocked = ST_LOCKED
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// CNT_W-bit up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset, clears the count
//   clear  in   synchronous clear, has priority over inc
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current count, registered
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/const_detect32.sv
// -----------------------------------------------------------------------------
// const_detect32
//
// Sink that checks a signed 32-bit valid/ready stream against the constant
// VALUE. After LOCK_COUNT consecutive matching samples it declares lock; while
// locked, MISS_LIMIT consecutive mismatches drop it again. Saturating totals of
// matching and mismatching samples are kept for self-check readout.
//
// Optional build macro CONST_DETECT_TOL_EN: adds parameter TOL and treats a
// sample as matching when |din - VALUE| <= TOL (33-bit signed difference).
// Without the macro the comparison is exact equality.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   din         in   signed sample
//   din_valid   in   sample present
//   din_ready   out  sample accepted this cycle (low only while clear is high)
//   clear       in   synchronous return to the reset state
//   locked      out  high while in the locked state
//   lock_pulse  out  one-cycle pulse on search -> locked
//   loss_pulse  out  one-cycle pulse on locked -> search
//   match_cnt   out  saturating count of accepted matching samples
//   err_cnt     out  saturating count of accepted mismatching samples
// -----------------------------------------------------------------------------
module const_detect32
    import const_detect_pkg::*;
#(
    parameter logic signed [31:0] VALUE      = 32'sd0,
    parameter int unsigned        LOCK_COUNT = 4,
    parameter int unsigned        MISS_LIMIT = 2,
`ifdef CONST_DETECT_TOL_EN
    parameter logic [30:0]        TOL        = 31'd0,
`endif
    parameter int unsigned        CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [31:0]  din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic                clear,
    output logic                locked,
    output logic                lock_pulse,
    output logic                loss_pulse,
    output logic [CNT_W-1:0]    match_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] MISS_TGT = RUN_W'(MISS_LIMIT);

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] run_inc;
    logic             lock_pulse_q, lock_pulse_d;
    logic             loss_pulse_q, loss_pulse_d;
    logic             accept;
    logic             match;

    // ------------------------------------------------------------------
    // Handshake: the block only stalls during a clear cycle.
    // ------------------------------------------------------------------
    assign din_ready = ~clear;
    assign accept    = din_valid & din_ready;

    // ------------------------------------------------------------------
    // Comparator
    // ------------------------------------------------------------------
`ifdef CONST_DETECT_TOL_EN
    logic [32:0] diff;
    logic [32:0] abs_diff;

    // Sign-extend both operands to 33 bits so the difference cannot wrap,
    // e.g. 32'h8000_0000 - 32'h7FFF_FFFF is -(2^32 - 1), still representable.
    assign diff     = {din[31], din} - {VALUE[31], VALUE};
    assign abs_diff = diff[32] ? (~diff + 33'd1) : diff;
    assign match    = (abs_diff <= {2'b00, TOL});
`else
    assign match = (din == VALUE);
`endif

    assign run_inc = run_q + 1'b1;

    // ------------------------------------------------------------------
    // Lock FSM and run counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StSearch;
            run_q        <= '0;
            lock_pulse_q <= 1'b0;
            loss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            lock_pulse_q <= lock_pulse_d;
            loss_pulse_q <= loss_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        lock_pulse_d = 1'b0;
        loss_pulse_d = 1'b0;

        if (clear) begin
            // Back to the reset state without announcing a loss.
            state_d = StSearch;
            run_d   = '0;
        end else if (accept) begin
            unique case (state_q)
                StSearch: begin
                    if (match) begin
                        if (run_inc == LOCK_TGT) begin
                            state_d      = StLocked;
                            run_d        = '0;
                            lock_pulse_d = 1'b1;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                StLocked: begin
                    if (!match) begin
                        if (run_inc == MISS_TGT) begin
                            state_d      = StSearch;
                            run_d        = '0;
                            loss_pulse_d = 1'b1;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        // An isolated miss is forgiven once a match follows.
                        run_d = '0;
                    end
                end
                default: begin
                    state_d = StSearch;
                    run_d   = '0;
                end
            endcase
        end
    end

    assign locked     = (state_q == StLocked);
    assign lock_pulse = lock_pulse_q;
    assign loss_pulse = loss_pulse_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (accept & match),
        .count (match_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (accept & ~match),
        .count (err_cnt)
    );

endmodule

// File: doc/const_detect32.md
Name: const_detect32

Overview:
- Sink-side counterpart to the design's constant sources.
- Accepts a signed 32-bit sample stream under a valid/ready handshake and compares each accepted sample against a compile-time constant.
- Declares lock after a run of consecutive matches and loss after a run of consecutive mismatches.
- Keeps saturating match and mismatch counters for bench and board-level self-checks of datapaths fed by constant sources.

Parameters:
VALUE, 0, signed 32-bit expected constant
LOCK_COUNT, 4, consecutive matches required to enter LOCKED (legal range 1..255)
MISS_LIMIT, 2, consecutive mismatches in LOCKED required to drop lock (legal range 1..255)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
din  in  32  signed sample
din_valid  in  1  sample present
din_ready  out  1  block accepts the sample this cycle
clear  in  1  synchronous clear of counters and state
locked  out  1  high while in LOCKED
lock_pulse  out  1  one-cycle pulse on SEARCH->LOCKED
loss_pulse  out  1  one-cycle pulse on LOCKED->SEARCH
match_cnt  out  CNT_W  total accepted matching samples, saturating
err_cnt  out  CNT_W  total accepted mismatching samples, saturating

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=SEARCH; locked, lock_pulse, loss_pulse = 0; match_cnt, err_cnt = 0; run counters = 0; din_ready = 1 once rst deasserts.
- Handshake:
  - A sample is accepted when din_valid and din_ready are both high on a rising clk edge.
  - din_ready is low only in a cycle where clear is high; otherwise it is 1.
  - Samples with din_valid low are ignored and leave all state untouched.
- Compare: match = (din == VALUE), as a full signed 32-bit equality.
- Run counter: 8-bit count of consecutive matches (SEARCH) or consecutive mismatches (LOCKED).
- State SEARCH:
  - Accepted match: increment the run counter.
  - Accepted mismatch: reset the run counter to 0.
  - When the incremented count reaches LOCK_COUNT, go to LOCKED in the same edge, zero the run counter, and assert lock_pulse for one cycle.
- State LOCKED:
  - Accepted mismatch: increment the run counter.
  - Accepted match: reset the run counter to 0.
  - When the count reaches MISS_LIMIT, go to SEARCH, zero the run counter, and assert loss_pulse for one cycle.
- Output latency:
  - locked, the pulses and both stat counters are registered and update on the edge that accepts the sample.
  - They are visible 1 cycle after acceptance.
- Statistics counters:
  - match_cnt increments on every accepted match; err_cnt on every accepted mismatch, in either state.
  - Both saturate at all-ones and never wrap.
- clear:
  - Synchronous. It has priority over any sample in the same cycle, but no sample can be accepted that cycle because din_ready=0.
  - Next state equals the reset state; no pulse is generated even if locked was 1.
- Boundaries:
  - LOCK_COUNT=1: the first match locks.
  - MISS_LIMIT=1: the first mismatch drops lock.
  - A lock and a loss cannot occur on the same edge.
- Reset mid-run: all state is lost immediately and asynchronously; pulses are cleared.

Optional Feature:
- Macro: CONST_DETECT_TOL_EN.
- Defined:
  - Adds parameter TOL (default 0, unsigned 31-bit).
  - match = (|din - VALUE| <= TOL), with the difference computed in 33-bit signed to avoid overflow.
  - All other behaviour is unchanged.
- Undefined: exact equality only; TOL does not exist.

Decomposition:
- Shared package/header const_detect_pkg: state encoding localparams (ST_SEARCH=1'b0, ST_LOCKED=1'b1) and the default RUN_W=8.
- One natural sub-module, sat_counter: CNT_W-bit saturating incrementer with sync clear and async reset, instantiated twice for match_cnt and err_cnt.
- FSM, run counter and comparator stay in the top level.

Test Plan:
- Reset: assert rst mid-stream with din_valid high -> all outputs 0 immediately; din_ready=1 after release.
- Lock: VALUE=5, LOCK_COUNT=4; feed 5,5,5,9,5,5,5,5 -> lock_pulse exactly once, one cycle after the 8th sample; match_cnt=7, err_cnt=1.
- Loss: from LOCKED with MISS_LIMIT=2; feed 7,5,7,7 -> stays locked through the isolated miss; loss_pulse after the 4th sample; locked=0.
- Gaps and clear: valid bubbles between matching samples -> lock still reached. clear while locked -> locked=0, counters 0, no loss_pulse, din_ready=0 that cycle.
- Saturation: CNT_W=4, VALUE=-1; 20 samples of 32'hFFFFFFFF -> match_cnt holds at 15.
- Tolerance (CONST_DETECT_TOL_EN, VALUE=100, TOL=2): 98, 102 and 101 match; 97 and 103 mismatch. VALUE=32'h7FFFFFFF with din=32'h80000000 -> mismatch, no overflow.
